// File: rtl/dmem_lsu_pkg.sv
// Shared definitions for the data-memory load/store unit:
// RV32I width codes, FSM states and byte-enable generation.
package dmem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  // Byte lanes touched by a store of the given width at a[1:0].
  function automatic logic [3:0] be_gen(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic [3:0] be;
    case (f3)
      F3_B:    be = 4'b0001 << a;
      F3_H:    be = a[1] ? 4'b1100 : 4'b0011;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between right-aligned core data and the
// word-wide RAM: store replication/enables, load extract/extend.
module dmem_lane_align
  import dmem_lsu_pkg::*;
(
  input  logic [2:0]  i_st_f3,
  input  logic [1:0]  i_st_addr,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_data,
  input  logic [2:0]  i_ld_f3,
  input  logic [1:0]  i_ld_addr,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [15:0] w_half;
  logic [7:0]  w_byte;

  assign o_st_be = be_gen(i_st_f3, i_st_addr);

  assign w_half = i_ld_addr[1] ? i_ld_word[31:16]
                               : i_ld_word[15:0];
  assign w_byte = i_ld_addr[0] ? w_half[15:8]
                               : w_half[7:0];

  // Replicate narrow store data onto every lane it may land in.
  always_comb begin
    o_st_data = i_st_data;
    case (i_st_f3)
      F3_B:    o_st_data = {4{i_st_data[7:0]}};
      F3_H:    o_st_data = {2{i_st_data[15:0]}};
      default: o_st_data = i_st_data;
    endcase
  end

  // Pick the addressed byte/half and sign- or zero-extend it.
  always_comb begin
    o_ld_data = i_ld_word;
    case (i_ld_f3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_ld_data = {24'h0, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_ld_data = {16'h0, w_half};
      default: o_ld_data = i_ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Data memory with valid/ready load/store port, configurable
// read latency, byte-enable writes and error responses.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_SIZE   = 256,
  parameter int RD_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [2:0]            i_req_funct3,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [31:0]           i_req_wdata,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_rdata,
  output logic                  o_rsp_err
);

  localparam int IDX_W = $clog2(MEM_SIZE);
  localparam logic [1:0] LAST = 2'(RD_LATENCY - 1);

  logic [31:0] r_mem [MEM_SIZE];

  state_e      r_state;
  logic [1:0]  r_cnt;
  logic        r_rsp_valid;
  logic        r_rsp_err;
  logic        r_ld_ok;
  logic [2:0]  r_f3;
  logic [1:0]  r_a;
  logic [31:0] r_word;

  logic [ADDR_WIDTH-3:0] w_hi;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_oor;
  logic                  w_mis;
  logic                  w_ill;
  logic                  w_err;
  logic                  w_wr_en;
  logic [3:0]            w_be;
  logic [31:0]           w_st_data;
  logic [31:0]           w_ld_data;

  assign w_hi  = i_req_addr[ADDR_WIDTH-1:2];
  assign w_idx = i_req_addr[IDX_W+1:2];
  // Word index beyond the array is an error, never a wrap.
  assign w_oor = |(w_hi >> IDX_W);

  assign w_mis =
    ((i_req_funct3 == F3_H || i_req_funct3 == F3_HU)
      && i_req_addr[0])
    || (i_req_funct3 == F3_W && i_req_addr[1:0] != 2'b00);

  assign w_ill = i_req_we
    ? !(i_req_funct3 inside {F3_B, F3_H, F3_W})
    : (i_req_funct3 inside {3'b011, 3'b110, 3'b111});

  assign w_err = w_oor || w_mis || w_ill;

  assign o_req_ready = (r_state == IDLE) && !i_rst;

  assign w_wr_en = i_req_valid && o_req_ready
                && i_req_we && !w_err;

  dmem_lane_align u_align (
    .i_st_f3   (i_req_funct3),
    .i_st_addr (i_req_addr[1:0]),
    .i_st_data (i_req_wdata),
    .o_st_be   (w_be),
    .o_st_data (w_st_data),
    .i_ld_f3   (r_f3),
    .i_ld_addr (r_a),
    .i_ld_word (r_word),
    .o_ld_data (w_ld_data)
  );

  // Store commits on its accept edge through the byte enables.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b])
          r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
      end
    end
  end

  // Request/response sequencing. Only one access is in flight,
  // so the word read at accept is simply held until the
  // response is taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_ld_ok     <= 1'b0;
      r_f3        <= F3_B;
      r_a         <= '0;
      r_word      <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_f3  <= i_req_funct3;
            r_a   <= i_req_addr[1:0];
            r_cnt <= 2'd1;
            if (w_err || i_req_we) begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_err;
              r_ld_ok     <= 1'b0;
            end else begin
              r_word <= r_mem[w_idx];
              if (RD_LATENCY == 1) begin
                r_state     <= RESP;
                r_rsp_valid <= 1'b1;
                r_ld_ok     <= 1'b1;
              end else begin
                r_state <= WAIT;
              end
            end
          end
        end
        WAIT: begin
          if (r_cnt == LAST) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_ld_ok     <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_ld_ok     <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_rdata = r_ld_ok ? w_ld_data : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Self-checking bench for dmem_lsu: one instance with
// RD_LATENCY=1 and one with RD_LATENCY=3, byte-array model.
module tb_dmem_lsu;

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [2:0]  req_f3    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] mm [2][1024];

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    bit          err;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl[11];

  dmem_lsu #(.ADDR_WIDTH(32), .MEM_SIZE(256), .RD_LATENCY(1)) dut1 (
    .i_clk(clk), .i_rst(rst[0]),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_we(req_we[0]), .i_req_funct3(req_f3[0]),
    .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rsp_ready[0]),
    .o_rsp_rdata(rsp_rdata[0]), .o_rsp_err(rsp_err[0])
  );

  dmem_lsu #(.ADDR_WIDTH(32), .MEM_SIZE(256), .RD_LATENCY(3)) dut3 (
    .i_clk(clk), .i_rst(rst[1]),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_we(req_we[1]), .i_req_funct3(req_f3[1]),
    .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rsp_ready[1]),
    .o_rsp_rdata(rsp_rdata[1]), .o_rsp_err(rsp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic bit m_err(input bit we, input logic [2:0] f3,
                               input logic [31:0] a);
    bit ill, mis, oor;
    ill = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7);
    mis = (f3[1:0] == 2'd1 && a % 2 != 0)
       || (f3[1:0] == 2'd2 && a % 4 != 0);
    oor = (a / 4) >= 256;
    return ill || mis || oor;
  endfunction

  // Reference: apply the access to the byte array, return response.
  task automatic m_apply(input int d, input bit we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         output bit e, output logic [31:0] rd);
    int n;
    logic [31:0] v;
    e = m_err(we, f3, a);
    rd = 32'h0;
    if (!e) begin
      n = 1 << f3[1:0];
      if (we) begin
        for (int i = 0; i < n; i++) mm[d][a + i] = wd[8*i +: 8];
      end else begin
        v = 32'h0;
        for (int i = 0; i < n; i++) v = v | (32'(mm[d][a + i]) << (8 * i));
        if (!f3[2] && n == 1 && v[7]) v = v | 32'hFFFFFF00;
        if (!f3[2] && n == 2 && v[15]) v = v | 32'hFFFF0000;
        rd = v;
      end
    end
  endtask

  task automatic xact(input int d, input bit we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int hold, output logic e,
                      output logic [31:0] rd, output int lat);
    int n;
    bit bad;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d] = we; req_f3[d] = f3;
    req_addr[d] = a; req_wdata[d] = wd;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 20) begin
      @(negedge clk); n++;
    end
    chk("accept_bound", (n < 20) ? 1 : 0, 1);
    @(posedge clk); #1;
    // keep valid high with junk fields: must be ignored while busy
    req_we[d] = 1'($urandom); req_f3[d] = 3'($urandom);
    req_addr[d] = $urandom; req_wdata[d] = $urandom;
    lat = 1; bad = 0; n = 0;
    @(negedge clk);
    while (rsp_valid[d] !== 1'b1 && n < 20) begin
      if (req_ready[d] !== 1'b0) bad = 1;
      @(negedge clk); n++; lat++;
    end
    chk("rsp_bound", (n < 20) ? 1 : 0, 1);
    if (req_ready[d] !== 1'b0) bad = 1;
    e = rsp_err[d]; rd = rsp_rdata[d];
    repeat (hold) begin
      @(negedge clk);
      if (rsp_valid[d] !== 1'b1 || rsp_err[d] !== e ||
          rsp_rdata[d] !== rd || req_ready[d] !== 1'b0) bad = 1;
    end
    chk("busy_stable", {31'h0, bad}, 0);
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    chk("idle_after", {30'h0, req_ready[d], rsp_valid[d]}, 2);
  endtask

  task automatic run(input int d, input bit we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd,
                     input int hold, input bit xe,
                     input logic [31:0] xrd);
    logic e;
    logic [31:0] rd;
    int lat;
    xact(d, we, f3, a, wd, hold, e, rd, lat);
    chk("rsp_err", {31'h0, e}, {31'h0, xe});
    chk("rsp_rdata", rd, xrd);
    chk("latency", lat, (we || xe) ? 1 : (d == 1 ? 3 : 1));
  endtask

  initial begin
    bit me;
    logic [31:0] mrd;
    logic [31:0] a, wd;
    bit we, bad;
    logic [2:0] f3;
    int d, sel;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0;
      req_f3[i] = 3'h0; req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
      rsp_ready[i] = 1'b0;
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_rsp_valid", {31'h0, rsp_valid[i]}, 0);
      chk("reset_rsp_err", {31'h0, rsp_err[i]}, 0);
      chk("reset_rsp_rdata", rsp_rdata[i], 0);
      chk("reset_req_ready", {31'h0, req_ready[i]}, 0);
      rst[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++)
      chk("post_reset_ready", {31'h0, req_ready[i]}, 1);

    // fill the low 16 words so later loads read known data
    for (int w = 0; w < 16; w++) begin
      for (int k = 0; k < 2; k++) begin
        wd = $urandom;
        m_apply(k, 1'b1, 3'b010, 32'(w * 4), wd, me, mrd);
        run(k, 1'b1, 3'b010, 32'(w * 4), wd, 0, me, mrd);
      end
    end

    tbl[0]  = '{1'b1, 3'b010, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b1, 3'b000, 32'h13,  32'h00000080, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 3'b000, 32'h13,  32'h0,        1'b0, 32'hFFFFFF80};
    tbl[4]  = '{1'b0, 3'b100, 32'h13,  32'h0,        1'b0, 32'h00000080};
    tbl[5]  = '{1'b0, 3'b001, 32'h12,  32'h0,        1'b0, 32'hFFFF80AD};
    tbl[6]  = '{1'b0, 3'b010, 32'h11,  32'h0,        1'b1, 32'h0};
    tbl[7]  = '{1'b1, 3'b001, 32'h21,  32'h1234,     1'b1, 32'h0};
    tbl[8]  = '{1'b1, 3'b010, 32'h400, 32'h55555555, 1'b1, 32'h0};
    tbl[9]  = '{1'b1, 3'b011, 32'h10,  32'h11111111, 1'b1, 32'h0};
    tbl[10] = '{1'b0, 3'b010, 32'h10,  32'h0,        1'b0, 32'h80ADBEEF};

    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 11; i++) begin
        m_apply(k, tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, me, mrd);
        run(k, tbl[i].we, tbl[i].f3, tbl[i].a, tbl[i].wd, k,
            tbl[i].err, tbl[i].rd);
      end
    end

    // long back-pressure on a 3-cycle load
    m_apply(1, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, me, mrd);
    run(1, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 0, me, mrd);
    run(1, 1'b0, 3'b010, 32'h30, 32'h0, 5, 1'b0, 32'hCAFEF00D);

    // reset while a load is waiting
    m_apply(1, 1'b1, 3'b010, 32'h14, 32'hA5A5_0F0F, me, mrd);
    run(1, 1'b1, 3'b010, 32'h14, 32'hA5A5_0F0F, 0, me, mrd);
    @(negedge clk);
    req_valid[1] = 1'b1; req_we[1] = 1'b0;
    req_f3[1] = 3'b010; req_addr[1] = 32'h14;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    chk("rst_mid_valid", {31'h0, rsp_valid[1]}, 0);
    chk("rst_mid_ready", {31'h0, req_ready[1]}, 0);
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    chk("rst_release_ready", {31'h0, req_ready[1]}, 1);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid[1] !== 1'b0) bad = 1;
    end
    chk("no_spurious_rsp", {31'h0, bad}, 0);
    run(1, 1'b0, 3'b010, 32'h14, 32'h0, 0, 1'b0, 32'hA5A50F0F);

    // random mixed traffic against the byte-array model
    for (int i = 0; i < 300; i++) begin
      d   = i % 2;
      we  = 1'($urandom);
      f3  = 3'($urandom);
      sel = $urandom_range(0, 7);
      if (sel == 0)      a = 32'h400 + $urandom_range(0, 63);
      else if (sel == 1) a = $urandom;
      else               a = $urandom_range(0, 63);
      wd = $urandom;
      m_apply(d, we, f3, a, wd, me, mrd);
      run(d, we, f3, a, wd, $urandom_range(0, 2), me, mrd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
